// File: rtl/relu_requant_stage.sv
// relu_requant_stage
//   Elastic output stage behind the adder trees. Each lane does a
//   round-half-up arithmetic right shift, then ReLU and unsigned saturation.
//   The stage is a two-register valid/ready pipeline. A sticky counter
//   tracks beats that had at least one saturated lane.
// Ports
//   clk, rst_n           clock, async active-low reset
//   in_valid/in_ready    input handshake; in_data packs LANES x BW_IN
//   out_valid/out_ready  output handshake; out_data packs LANES x BW_OUT
//   sat_clr              synchronous clear of sat_count
//   sat_count            saturating count of saturated beats

// Per-lane datapath: the S1 (shifted value) and S2 (clamped value) registers.
// Both registers are load-enabled by the top-level pipeline control.
module relu_requant_lane #(
  parameter int BW_IN     = 32,
  parameter int SIGNED_IN = 1,
  parameter int SHIFT     = 0,
  parameter int ROUND     = 1,
  parameter int BW_OUT    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_ld1,
  input  logic              i_ld2,
  input  logic [BW_IN-1:0]  i_x,
  output logic [BW_OUT-1:0] o_y,
  output logic              o_sat    // S1 value would saturate (valid-agnostic)
);
  localparam int IW = BW_IN + 2;
  localparam int RS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [IW-1:0] RND_ONE = {{(IW-1){1'b0}}, 1'b1};
  localparam logic [IW-1:0] RND     = (ROUND != 0 && SHIFT > 0) ? (RND_ONE << RS) : '0;

  logic signed [IW-1:0] w_x;
  logic signed [IW-1:0] w_r;
  logic signed [IW-1:0] w_q;
  logic signed [IW-1:0] r_q;
  logic                 w_neg;
  logic [BW_OUT-1:0]    w_y;
  logic [BW_OUT-1:0]    r_y;

  // Two spare bits: one for the sign of unsigned inputs, one so the
  // rounding add cannot carry into the sign.
  generate
    if (SIGNED_IN != 0) begin : g_sext
      assign w_x = {{2{i_x[BW_IN-1]}}, i_x};
    end else begin : g_zext
      assign w_x = {2'b00, i_x};
    end
  endgenerate

  assign w_r = w_x + $signed(RND);
  assign w_q = w_r >>> SHIFT;

  // Any set bit at or above BW_OUT on a non-negative value means
  // the value exceeds 2^BW_OUT-1.
  assign w_neg = r_q[IW-1];
  assign o_sat = !w_neg && (|r_q[IW-2:BW_OUT]);
  assign w_y   = w_neg ? '0 : (o_sat ? '1 : r_q[BW_OUT-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
      r_y <= '0;
    end else begin
      if (i_ld1) r_q <= w_q;
      if (i_ld2) r_y <= w_y;
    end
  end

  assign o_y = r_y;
endmodule

module relu_requant_stage #(
  parameter int LANES     = 4,
  parameter int BW_IN     = 32,
  parameter int SIGNED_IN = 1,
  parameter int SHIFT     = 0,
  parameter int ROUND     = 1,
  parameter int BW_OUT    = 8,
  parameter int BW_CNT    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*BW_IN-1:0]  in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*BW_OUT-1:0] out_data,
  input  logic                    sat_clr,
  output logic [BW_CNT-1:0]       sat_count
);
  logic [LANES-1:0][BW_IN-1:0]  w_in;
  logic [LANES-1:0][BW_OUT-1:0] w_out;
  logic [LANES-1:0]             w_sat;
  logic                         r_s1_vld;
  logic                         r_s2_vld;
  logic                         w_ld1;
  logic                         w_ld2;
  logic                         w_xfer;
  logic                         w_inc;
  logic [BW_CNT-1:0]            r_cnt;

  // S2 frees up when empty or being drained; S1 frees up when empty or moving into S2.
  assign w_ld2  = !r_s2_vld || out_ready;
  assign w_ld1  = !r_s1_vld || w_ld2;
  assign w_xfer = r_s1_vld && w_ld2;
  assign w_inc  = w_xfer && (|w_sat);

  assign w_in = in_data;

  // Data regs only load on real beats, so idle bubbles leave out_data untouched.
  relu_requant_lane #(
    .BW_IN(BW_IN), .SIGNED_IN(SIGNED_IN), .SHIFT(SHIFT),
    .ROUND(ROUND), .BW_OUT(BW_OUT)
  ) u_lane [LANES-1:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .i_ld1 (w_ld1 && in_valid),
    .i_ld2 (w_xfer),
    .i_x   (w_in),
    .o_y   (w_out),
    .o_sat (w_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (w_ld1) r_s1_vld <= in_valid;
      if (w_ld2) r_s2_vld <= r_s1_vld;
      // Clear wins over the old value, but a same-cycle increment still counts.
      if (sat_clr)
        r_cnt <= w_inc ? {{(BW_CNT-1){1'b0}}, 1'b1} : '0;
      else if (w_inc && !(&r_cnt))
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign in_ready  = w_ld1;
  assign out_valid = r_s2_vld;
  assign out_data  = w_out;
  assign sat_count = r_cnt;
endmodule

// File: tb/tb_relu_requant_stage.sv
module tb_relu_requant_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        sat_clr;
  logic [3:0]  sat_count;

  int nchk  = 0;
  int nfail = 0;

  relu_requant_stage #(
    .LANES(1), .BW_IN(16), .SIGNED_IN(1), .SHIFT(4),
    .ROUND(1), .BW_OUT(8), .BW_CNT(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sat_clr   (sat_clr),
    .sat_count (sat_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One beat with out_ready held high: accepted at edge N, visible after edge N+1.
  task automatic send(input string tag, input logic [15:0] x,
                      input logic [7:0] exp_y, input logic [3:0] exp_cnt);
    in_valid = 1'b1;
    in_data  = x;
    #1;
    check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check({tag, "_lat"}, 32'(out_valid), 32'd0);
    tick();
    check({tag, "_vld"}, 32'(out_valid), 32'd1);
    check({tag, "_dat"}, 32'(out_data), 32'(exp_y));
    check({tag, "_cnt"}, 32'(sat_count), 32'(exp_cnt));
  endtask

  logic [15:0] vin  [9] = '{16'h0128, 16'h0018, 16'h0017,
                            16'hFFFB, 16'h8000, 16'hFFF8,
                            16'h7FFF, 16'h0FF7, 16'h0FF8};
  logic [7:0]  vout [9] = '{8'd19, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd255};
  logic [3:0]  vcnt [9] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd2};

  initial begin
    int sent, got, cnt;
    logic stall_prev, acc, cons;
    logic [7:0] prev_data;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; sat_clr = 1'b0;
    #1;
    check("rst_ovld", 32'(out_valid), 32'd0);
    check("rst_odat", 32'(out_data), 32'd0);
    check("rst_cnt", 32'(sat_count), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    check("rst_irdy", 32'(in_ready), 32'd1);
    tick();

    // Rounding, ReLU and saturation vectors
    for (int i = 0; i < 9; i++) send($sformatf("vec%0d", i), vin[i], vout[i], vcnt[i]);

    // 20 saturating beats streamed back to back; counter must stick at 15
    in_valid = 1'b1;
    in_data  = 16'h7FFF;
    for (int i = 0; i < 20; i++) tick();
    in_valid = 1'b0;
    tick(); tick();
    check("cnt_hold", 32'(sat_count), 32'd15);

    // Clear in the same cycle as a saturating S1->S2 transfer
    in_valid = 1'b1;
    in_data  = 16'h7FFF;
    tick();
    in_valid = 1'b0;
    sat_clr  = 1'b1;
    tick();
    sat_clr  = 1'b0;
    check("clr_inc_cnt", 32'(sat_count), 32'd1);
    check("clr_inc_dat", 32'(out_data), 32'd255);
    // Clear alone
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    check("clr_only", 32'(sat_count), 32'd0);
    tick();

    // Randomised backpressure stream 0x10..0x80 -> 1..8
    sent = 0; got = 0; cnt = 0; stall_prev = 1'b0; prev_data = '0;
    for (int cyc = 0; cyc < 400 && got < 8; cyc++) begin
      in_valid  = (sent < 8) && ($urandom_range(0, 2) != 0);
      in_data   = 16'((sent + 1) * 16);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      check("bp_irdy", 32'(in_ready), 32'(!(cnt == 2 && !out_ready)));
      if (stall_prev) begin
        check("bp_hold_v", 32'(out_valid), 32'd1);
        check("bp_hold_d", 32'(out_data), 32'(prev_data));
      end
      acc  = in_valid && in_ready;
      cons = out_valid && out_ready;
      if (cons) begin
        check("bp_order", 32'(out_data), 32'(got + 1));
        got++;
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      if (acc) sent++;
      cnt = cnt + int'(acc) - int'(cons);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("bp_count", 32'(got), 32'd8);
    tick(); tick();
    check("bp_nodup", 32'(out_valid), 32'd0);

    // Fill both stages under stall, then reset mid-stream
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h7FFF;
    tick(); tick();
    check("mid_full_v", 32'(out_valid), 32'd1);
    check("mid_full_r", 32'(in_ready), 32'd0);
    check("mid_cnt", 32'(sat_count), 32'd1);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_v", 32'(out_valid), 32'd0);
    check("mid_rst_cnt", 32'(sat_count), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("mid_rel_r", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    tick();
    send("post_rst", 16'h0040, 8'd4, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

  // Watchdog against a hung simulation
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
